// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the PC next-value, fetches over a req/ack
// memory handshake and presents instruction + PC+4 to decode through a
// valid/ready IF/ID register backed by a one-entry skid buffer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target
);

    // The skid buffer is full exactly when the FSM is in STALL, so it needs
    // no valid bit of its own.
    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] drain_addr_q, drain_addr_d;

    logic        xfer;
    logic        slot_free;
    logic [31:0] pc_plus4;
    logic [31:0] redir_pc;

    assign xfer      = if_valid_q && id_ready && !redirect_valid;
    assign slot_free = !if_valid_q || xfer;
    assign pc_plus4  = pc_in + 32'd4;
    assign redir_pc  = redirect_target & ~32'h3;

    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc_plus4 = if_pc4_q;

    // Next-state, PC selection and memory request generation.
    always_comb begin
        state_d      = state_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc4_d     = if_pc4_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        drain_addr_d = drain_addr_q;
        pc_next      = pc_in;
        imem_req     = 1'b0;
        imem_addr    = pc_in;

        case (state_q)
            START: begin
                // Redirects are ignored here; the PC register is loaded with
                // the reset vector so FETCH starts from it.
                pc_next = RESET_PC;
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    pc_next    = redir_pc;
                    if_valid_d = 1'b0;
                    if (!imem_ack) begin
                        // Request still outstanding: finish it at the old
                        // address before issuing the target fetch.
                        drain_addr_d = pc_in;
                        state_d      = DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_next = pc_plus4;
                    if (slot_free) begin
                        if_valid_d = 1'b1;
                        if_instr_d = imem_rdata;
                        if_pc4_d   = pc_plus4;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = pc_plus4;
                        state_d      = STALL;
                    end
                end else if (xfer) begin
                    if_valid_d = 1'b0;
                end
            end
            STALL: begin
                if (redirect_valid) begin
                    pc_next    = redir_pc;
                    if_valid_d = 1'b0;
                    state_d    = FETCH;
                end else if (xfer) begin
                    if_instr_d = skid_instr_q;
                    if_pc4_d   = skid_pc4_q;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
                if (redirect_valid) begin
                    pc_next    = redir_pc;
                    if_valid_d = 1'b0;
                end
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = START;
            end
        endcase
    end

    // Control state and the IF/ID register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= START;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'h0;
            if_pc4_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc4_q   <= if_pc4_d;
        end
    end

    // Skid payload and abandoned address; only read while the FSM says valid.
    always_ff @(posedge clk) begin
        skid_instr_q <= skid_instr_d;
        skid_pc4_q   <= skid_pc4_d;
        drain_addr_q <= drain_addr_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic,
// with a scoreboard of the expected in-order instruction stream to decode.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in = 32'h0;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;

    int total = 0;
    int bad   = 0;
    int n_xfer = 0;
    int lat_fixed = 0;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .pc_next         (pc_next),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc_plus4     (if_pc_plus4),
        .id_ready        (id_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    always #5 clk = ~clk;

    // PC register without enable: loads pc_next every edge
    always @(posedge clk) pc_in <= pc_next;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Memory: per-request latency (fixed or random 0..3 wait cycles)
    int  mem_cnt  = 0;
    bit  mem_busy = 0;
    always @(posedge clk) begin
        #1;
        if (reset || !imem_req) begin
            imem_ack = 1'b0;
            mem_busy = 0;
        end else begin
            if (!mem_busy) begin
                mem_busy = 1;
                mem_cnt  = (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
            end
            if (mem_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = memword(imem_addr);
                mem_busy   = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                mem_cnt--;
            end
        end
    end

    // Scoreboard: decode must see a gapless sequential stream from the reset
    // vector, restarting at each redirect target, with stable requests.
    logic [31:0] exp_pc     = RESET_PC;
    bit          prev_wait  = 0;
    logic [31:0] prev_addr  = 32'h0;
    bit          prev_redir = 0;
    always @(posedge clk) begin
        #4;
        if (reset) begin
            exp_pc     = RESET_PC;
            prev_wait  = 0;
            prev_redir = 0;
        end else begin
            if (prev_wait) begin
                chk("hold_req", {31'h0, imem_req}, 32'h1);
                chk("hold_addr", imem_addr, prev_addr);
            end
            if (prev_redir) chk("squash_valid", {31'h0, if_valid}, 32'h0);
            if (redirect_valid) begin
                chk("redir_pc_next", pc_next, redirect_target & ~32'h3);
                exp_pc = redirect_target & ~32'h3;
            end else begin
                if (imem_req && !imem_ack) chk("wait_pc_next", pc_next, pc_in);
                if (if_valid && id_ready) begin
                    chk("xfer_pc4", if_pc_plus4, exp_pc + 32'd4);
                    chk("xfer_instr", if_instr, memword(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    n_xfer++;
                end
            end
            prev_wait  = imem_req && !imem_ack;
            prev_addr  = imem_addr;
            prev_redir = redirect_valid;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset           = 1'b1;
        id_ready        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        lat_fixed       = 0;

        // reset state
        tick();
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc4", if_pc_plus4, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_pc_next", pc_next, RESET_PC);
        tick();
        reset = 1'b0;
        #1;
        chk("start_pc_next", pc_next, RESET_PC);

        // zero-wait streaming
        for (int k = 1; k <= 6; k++) begin
            tick();
            #1;
            chk("stream_addr", imem_addr, 32'(4 * (k - 1)));
            if (k >= 2) begin
                chk("stream_valid", {31'h0, if_valid}, 32'h1);
                chk("stream_pc4", if_pc_plus4, 32'(4 * (k - 1)));
                chk("stream_instr", if_instr, memword(32'(4 * (k - 2))));
            end
        end

        // redirect to 0x10, then a 3-cycle wait there
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h10;
        lat_fixed       = 3;
        #1;
        chk("r10_pc_next", pc_next, 32'h10);
        for (int k = 0; k < 3; k++) begin
            tick();
            redirect_valid = 1'b0;
            #1;
            chk("wait_addr", imem_addr, 32'h10);
            chk("wait_pc_next", pc_next, 32'h10);
            chk("wait_req", {31'h0, imem_req}, 32'h1);
        end
        tick();
        lat_fixed = 0;
        #1;
        chk("ack_pc_next", pc_next, 32'h14);
        tick();
        #1;
        chk("late_valid", {31'h0, if_valid}, 32'h1);
        chk("late_pc4", if_pc_plus4, 32'h14);

        // decode backpressure with 0x20 in IF/ID
        n = 0;
        while (!(if_valid && if_pc_plus4 == 32'h24) && n < 50) begin
            tick();
            n++;
        end
        chk("reach_20", if_pc_plus4, 32'h24);
        id_ready = 1'b0;
        #1;
        chk("skid_pc_next", pc_next, 32'h28);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk("stall_req", {31'h0, imem_req}, 32'h0);
            chk("stall_pc_next", pc_next, 32'h28);
            chk("stall_pc4", if_pc_plus4, 32'h24);
        end
        tick();
        id_ready = 1'b1;
        #1;
        chk("stall_req4", {31'h0, imem_req}, 32'h0);
        tick();
        lat_fixed = 5;
        #1;
        chk("unskid_valid", {31'h0, if_valid}, 32'h1);
        chk("unskid_pc4", if_pc_plus4, 32'h28);
        chk("unskid_instr", if_instr, memword(32'h24));
        chk("unskid_addr", imem_addr, 32'h28);

        // redirect to 0x103 while 0x40 is outstanding
        n = 0;
        while (imem_addr !== 32'h40 && n < 200) begin
            tick();
            n++;
        end
        chk("reach_40", imem_addr, 32'h40);
        chk("pend_40", {31'h0, imem_ack}, 32'h0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h103;
        #1;
        chk("r103_pc_next", pc_next, 32'h100);
        tick();
        redirect_valid = 1'b0;
        #1;
        n = 0;
        while (!imem_ack && n < 20) begin
            chk("drain_addr", imem_addr, 32'h40);
            chk("drain_valid", {31'h0, if_valid}, 32'h0);
            chk("drain_pc_next", pc_next, 32'h100);
            tick();
            #1;
            n++;
        end
        chk("drain_ack", {31'h0, imem_ack}, 32'h1);
        chk("drain_ack_addr", imem_addr, 32'h40);
        lat_fixed = 0;
        tick();
        #1;
        chk("post_drain_addr", imem_addr, 32'h100);
        chk("post_drain_valid", {31'h0, if_valid}, 32'h0);
        tick();
        #1;
        chk("tgt_valid", {31'h0, if_valid}, 32'h1);
        chk("tgt_pc4", if_pc_plus4, 32'h104);
        chk("tgt_instr", if_instr, memword(32'h100));

        // redirect with skid full and IF/ID valid
        id_ready = 1'b0;
        tick();
        #1;
        chk("s1_req", {31'h0, imem_req}, 32'h0);
        chk("s1_valid", {31'h0, if_valid}, 32'h1);
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        id_ready        = 1'b1;
        #1;
        chk("s1_pc_next", pc_next, 32'h200);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("s2_valid", {31'h0, if_valid}, 32'h0);
        chk("s2_addr", imem_addr, 32'h200);
        tick();
        #1;
        chk("s3_pc4", if_pc_plus4, 32'h204);

        // address wrap
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        lat_fixed = 10;
        #1;
        chk("wrap_pc4", if_pc_plus4, 32'h0);
        chk("wrap_next_addr", imem_addr, 32'h0);
        chk("wrap_instr", if_instr, memword(32'hFFFF_FFFC));

        // async reset in DRAIN
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("pre_rst_req", {31'h0, imem_req}, 32'h1);
        chk("pre_rst_addr", imem_addr, 32'h4);
        reset = 1'b1;
        #1;
        chk("arst_req", {31'h0, imem_req}, 32'h0);
        chk("arst_valid", {31'h0, if_valid}, 32'h0);
        chk("arst_instr", if_instr, 32'h0);
        chk("arst_pc4", if_pc_plus4, 32'h0);
        chk("arst_pc_next", pc_next, RESET_PC);
        tick();
        reset     = 1'b0;
        lat_fixed = -1;

        // randomized traffic
        n_xfer = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            id_ready = ($urandom_range(0, 3) != 0);
            if (i >= 3 && $urandom_range(0, 15) == 0) begin
                redirect_valid  = 1'b1;
                redirect_target = ($urandom_range(0, 7) == 0) ?
                                  (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) :
                                  ($urandom & 32'h0000_3FFF);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("progress", {31'h0, n_xfer > 500}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
